// File: rtl/test_csr_defs.sv
// test_csr_defs: shared HE-LB CSR definitions.
//   - 64-bit slot offsets of every CSR (byte addresses, bits [2:0] zero)
//   - t_csr_reg: decoded register identifier plus csr_decode() to map an offset to it
//   - t_info0: layout of the constant INFO0 register
//   - t_lb_state: start/stop control FSM encoding (also reported in STATUS1[34:32])
//   - bus_bytes(): data-beat width in bytes for a given bus_width_shift
package test_csr_defs;

    localparam logic [15:0] CSR_DFH          = 16'h0000;
    localparam logic [15:0] CSR_ID_L         = 16'h0008;
    localparam logic [15:0] CSR_ID_H         = 16'h0010;
    localparam logic [15:0] CSR_SCRATCHPAD0  = 16'h0100;  // SCRATCHPAD1 is the upper word (0x104)
    localparam logic [15:0] CSR_DSM_BASEL    = 16'h0110;  // DSM_BASEH is the upper word (0x114)
    localparam logic [15:0] CSR_SRC_ADDR     = 16'h0120;
    localparam logic [15:0] CSR_DST_ADDR     = 16'h0128;
    localparam logic [15:0] CSR_NUM_LINES    = 16'h0130;
    localparam logic [15:0] CSR_CTL          = 16'h0138;
    localparam logic [15:0] CSR_CFG          = 16'h0140;
    localparam logic [15:0] CSR_INACT_THRESH = 16'h0148;
    localparam logic [15:0] CSR_STATUS0      = 16'h0160;
    localparam logic [15:0] CSR_STATUS1      = 16'h0168;
    localparam logic [15:0] CSR_ERROR        = 16'h0170;
    localparam logic [15:0] CSR_STRIDE       = 16'h0178;
    localparam logic [15:0] CSR_INFO0        = 16'h0180;

    typedef enum logic [4:0] {
        R_NONE,
        R_DFH,
        R_ID_L,
        R_ID_H,
        R_SCRATCH,
        R_DSM_BASE,
        R_SRC_ADDR,
        R_DST_ADDR,
        R_NUM_LINES,
        R_CTL,
        R_CFG,
        R_INACT_THRESH,
        R_STATUS0,
        R_STATUS1,
        R_ERROR,
        R_STRIDE,
        R_INFO0
    } t_csr_reg;

    typedef struct packed {
        logic [31:0] rsvd;
        logic [4:0]  local_mem_bus_width_shift;
        logic [1:0]  bus_width_shift;
        logic        atomics_supported;
        logic [7:0]  he_lb_api_version;
        logic [15:0] clk_mhz;
    } t_info0;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        STOPPING = 3'd2,
        DONE     = 3'd3
    } t_lb_state;

    // Bytes per data beat: 64B base bus scaled by 2**shift.
    function automatic int unsigned bus_bytes(input int unsigned shift);
        return 32'd64 << shift;
    endfunction

    function automatic t_csr_reg csr_decode(input logic [15:0] off);
        t_csr_reg r;
        case (off)
            CSR_DFH:          r = R_DFH;
            CSR_ID_L:         r = R_ID_L;
            CSR_ID_H:         r = R_ID_H;
            CSR_SCRATCHPAD0:  r = R_SCRATCH;
            CSR_DSM_BASEL:    r = R_DSM_BASE;
            CSR_SRC_ADDR:     r = R_SRC_ADDR;
            CSR_DST_ADDR:     r = R_DST_ADDR;
            CSR_NUM_LINES:    r = R_NUM_LINES;
            CSR_CTL:          r = R_CTL;
            CSR_CFG:          r = R_CFG;
            CSR_INACT_THRESH: r = R_INACT_THRESH;
            CSR_STATUS0:      r = R_STATUS0;
            CSR_STATUS1:      r = R_STATUS1;
            CSR_ERROR:        r = R_ERROR;
            CSR_STRIDE:       r = R_STRIDE;
            CSR_INFO0:        r = R_INFO0;
            default:          r = R_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/he_lb_ctl_fsm.sv
// he_lb_ctl_fsm: HE-LB start/stop control FSM.
//   clk, rst        clock, asynchronous active-high reset
//   ctl_wr          one-cycle strobe: CTL low word written this cycle
//   ctl_wdata       CTL[2:0] being written ([0] engine enable, [1] start, [2] stop)
//   eng_busy/done   engine state inputs
//   eng_start       one-cycle pulse in the first cycle spent in RUN
//   eng_stop        high while STOPPING
//   fsm_state       current state (STATUS1[34:32])
//   run_cycles      cycles spent in RUN/STOPPING since the last start, saturating
module he_lb_ctl_fsm
    import test_csr_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ctl_wr,
    input  logic [2:0]  ctl_wdata,
    input  logic        eng_busy,
    input  logic        eng_done,
    output logic        eng_start,
    output logic        eng_stop,
    output t_lb_state   fsm_state,
    output logic [31:0] run_cycles
);

    t_lb_state   state_q, state_d;
    logic        start_q, start_d;
    logic [31:0] run_cycles_q, run_cycles_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            start_q      <= 1'b0;
            run_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            run_cycles_q <= run_cycles_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        run_cycles_d = run_cycles_q;

        if ((state_q == RUN || state_q == STOPPING) && run_cycles_q != '1) begin
            run_cycles_d = run_cycles_q + 32'd1;
        end

        case (state_q)
            IDLE, DONE: begin
                if (ctl_wr && ctl_wdata[0] && ctl_wdata[1]) begin
                    state_d      = RUN;
                    run_cycles_d = '0;
                end
            end
            RUN: begin
                if (eng_done) begin
                    state_d = DONE;
                end else if (ctl_wr && ctl_wdata[2]) begin
                    state_d = STOPPING;
                end
            end
            STOPPING: begin
                if (!eng_busy) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Disabling the engine wins over every other transition.
        if (ctl_wr && !ctl_wdata[0]) begin
            state_d      = IDLE;
            run_cycles_d = '0;
        end

        start_d = (state_d == RUN) && (state_q != RUN);
    end

    assign eng_start  = start_q;
    assign eng_stop   = (state_q == STOPPING);
    assign fsm_state  = state_q;
    assign run_cycles = run_cycles_q;

endmodule

// File: rtl/he_lb_csr_block.sv
// he_lb_csr_block: MMIO CSR register file for the HE-LB exerciser.
//   clk, rst                        clock, asynchronous active-high reset
//   csr_wr_*                        write request (always ready); size 0=32b, 1=64b
//   csr_rd_*                        read request; ready while the response buffer can take data
//   csr_rsp_valid/ready/data        1-entry read response buffer, 32b reads zero-extended
//   csr_rsp_err                     (HE_LB_CSR_RD_ERR_EN only) unmapped/misaligned read flag
//   cfg_*                           engine configuration registers
//   eng_rst_n/eng_start/eng_stop    engine control (CTL[0], start pulse, stop level)
//   eng_busy/done/num_*/error       engine status inputs
// Optional feature macro: HE_LB_CSR_RD_ERR_EN (read error flag + sticky ERROR[31] on bad writes).
// Without it, misaligned accesses (64b at addr[2]=1) behave as unmapped.
module he_lb_csr_block
    import test_csr_defs::*;
#(
    parameter int unsigned ADDR_W          = 16,
    parameter logic [63:0] DFH_VAL         = 64'h0,
    parameter logic [63:0] ID_L_VAL        = 64'h0,
    parameter logic [63:0] ID_H_VAL        = 64'h0,
    parameter int unsigned CLK_MHZ         = 250,
    parameter logic [7:0]  API_VERSION     = 8'h02,
    parameter bit          ATOMICS         = 1'b1,
    parameter int unsigned BUS_WIDTH_SHIFT = 1,
    parameter int unsigned LM_WIDTH_SHIFT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              csr_wr_valid,
    output logic              csr_wr_ready,
    input  logic [ADDR_W-1:0] csr_wr_addr,
    input  logic              csr_wr_size,
    input  logic [63:0]       csr_wr_data,
    input  logic              csr_rd_valid,
    output logic              csr_rd_ready,
    input  logic [ADDR_W-1:0] csr_rd_addr,
    input  logic              csr_rd_size,
    output logic              csr_rsp_valid,
    input  logic              csr_rsp_ready,
    output logic [63:0]       csr_rsp_data,
`ifdef HE_LB_CSR_RD_ERR_EN
    output logic              csr_rsp_err,
`endif
    output logic [63:0]       cfg_src_addr,
    output logic [63:0]       cfg_dst_addr,
    output logic [31:0]       cfg_num_lines,
    output logic [31:0]       cfg_cfg,
    output logic [31:0]       cfg_stride,
    output logic [31:0]       cfg_inact_thresh,
    output logic [63:0]       cfg_dsm_base,
    output logic              eng_rst_n,
    output logic              eng_start,
    output logic              eng_stop,
    input  logic              eng_busy,
    input  logic              eng_done,
    input  logic [31:0]       eng_num_reads,
    input  logic [31:0]       eng_num_writes,
    input  logic [31:0]       eng_error
);

    localparam t_info0 INFO0 = '{
        rsvd:                      '0,
        local_mem_bus_width_shift: 5'(LM_WIDTH_SHIFT),
        bus_width_shift:           2'(BUS_WIDTH_SHIFT),
        atomics_supported:         ATOMICS,
        he_lb_api_version:         API_VERSION,
        clk_mhz:                   16'(CLK_MHZ)
    };

    // 32b write into a 64b slot: addr[2] selects which word is replaced.
    function automatic logic [63:0] merge64(input logic [63:0] old, input logic [63:0] wd,
                                            input logic size, input logic hi);
        logic [63:0] r;
        if (size)    r = wd;
        else if (hi) r = {wd[31:0], old[31:0]};
        else         r = {old[63:32], wd[31:0]};
        return r;
    endfunction

    logic [63:0] scratch_q,  scratch_d;
    logic [63:0] dsm_base_q, dsm_base_d;
    logic [63:0] src_addr_q, src_addr_d;
    logic [63:0] dst_addr_q, dst_addr_d;
    logic [31:0] num_lines_q, num_lines_d;
    logic [31:0] ctl_q, ctl_d;
    logic [31:0] cfg_q, cfg_d;
    logic [31:0] inact_q, inact_d;
    logic [31:0] stride_q, stride_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [63:0] rsp_data_q, rsp_data_d;
`ifdef HE_LB_CSR_RD_ERR_EN
    logic        rsp_err_q, rsp_err_d;
    logic        wr_err_q, wr_err_d;
`endif

    logic [ADDR_W-1:0] rd_slot, wr_slot;
    t_csr_reg          rd_reg, wr_reg;
    logic              rd_misalign, wr_misalign;
    logic              rd_accept, rd_bad;
    logic              wr_en, wr_lo, ctl_wr;
    logic [63:0]       rd_slot_data, rd_data;
    logic              rd_mapped;
    logic [31:0]       err_vec;
    t_lb_state         fsm_state;
    logic [31:0]       run_cycles;

    // Slot decode ignores addr[2:0]; addresses beyond the 16-bit map never hit.
    assign rd_slot = csr_rd_addr & ~ADDR_W'(7);
    assign wr_slot = csr_wr_addr & ~ADDR_W'(7);
    assign rd_reg  = (ADDR_W'(16'(rd_slot)) == rd_slot) ? csr_decode(16'(rd_slot)) : R_NONE;
    assign wr_reg  = (ADDR_W'(16'(wr_slot)) == wr_slot) ? csr_decode(16'(wr_slot)) : R_NONE;

    assign rd_misalign = csr_rd_size & csr_rd_addr[2];
    assign wr_misalign = csr_wr_size & csr_wr_addr[2];

    assign csr_wr_ready = 1'b1;
    assign csr_rd_ready = !rsp_valid_q || csr_rsp_ready;
    assign rd_accept    = csr_rd_valid && csr_rd_ready;

    assign wr_en  = csr_wr_valid && !wr_misalign;
    assign wr_lo  = wr_en && !csr_wr_addr[2];
    assign ctl_wr = wr_lo && (wr_reg == R_CTL);

`ifdef HE_LB_CSR_RD_ERR_EN
    assign err_vec = eng_error | {wr_err_q, 31'b0};
`else
    assign err_vec = eng_error;
`endif

    // Read mux works on current register state, so a same-cycle write is not visible.
    always_comb begin
        rd_slot_data = '0;
        rd_mapped    = 1'b1;
        case (rd_reg)
            R_DFH:          rd_slot_data = DFH_VAL;
            R_ID_L:         rd_slot_data = ID_L_VAL;
            R_ID_H:         rd_slot_data = ID_H_VAL;
            R_SCRATCH:      rd_slot_data = scratch_q;
            R_DSM_BASE:     rd_slot_data = dsm_base_q;
            R_SRC_ADDR:     rd_slot_data = src_addr_q;
            R_DST_ADDR:     rd_slot_data = dst_addr_q;
            R_NUM_LINES:    rd_slot_data = {32'h0, num_lines_q};
            R_CTL:          rd_slot_data = {32'h0, ctl_q};
            R_CFG:          rd_slot_data = {32'h0, cfg_q};
            R_INACT_THRESH: rd_slot_data = {32'h0, inact_q};
            R_STATUS0:      rd_slot_data = {eng_num_writes, eng_num_reads};
            R_STATUS1:      rd_slot_data = {29'b0, fsm_state, run_cycles};
            R_ERROR:        rd_slot_data = {32'h0, err_vec};
            R_STRIDE:       rd_slot_data = {32'h0, stride_q};
            R_INFO0:        rd_slot_data = INFO0;
            default:        rd_mapped    = 1'b0;
        endcase

        rd_bad = !rd_mapped || rd_misalign;
        if (rd_bad)              rd_data = '0;
        else if (csr_rd_size)    rd_data = rd_slot_data;
        else if (csr_rd_addr[2]) rd_data = {32'h0, rd_slot_data[63:32]};
        else                     rd_data = {32'h0, rd_slot_data[31:0]};
    end

    always_comb begin
        scratch_d   = scratch_q;
        dsm_base_d  = dsm_base_q;
        src_addr_d  = src_addr_q;
        dst_addr_d  = dst_addr_q;
        num_lines_d = num_lines_q;
        ctl_d       = ctl_q;
        cfg_d       = cfg_q;
        inact_d     = inact_q;
        stride_d    = stride_q;

        if (wr_en) begin
            case (wr_reg)
                R_SCRATCH:  scratch_d  = merge64(scratch_q,  csr_wr_data, csr_wr_size, csr_wr_addr[2]);
                R_DSM_BASE: dsm_base_d = merge64(dsm_base_q, csr_wr_data, csr_wr_size, csr_wr_addr[2]);
                R_SRC_ADDR: src_addr_d = merge64(src_addr_q, csr_wr_data, csr_wr_size, csr_wr_addr[2]);
                R_DST_ADDR: dst_addr_d = merge64(dst_addr_q, csr_wr_data, csr_wr_size, csr_wr_addr[2]);
                default: ;
            endcase
        end

        // 32-bit registers live in the low word of their slot; upper-word writes are dropped.
        if (wr_lo) begin
            case (wr_reg)
                R_NUM_LINES:    num_lines_d = csr_wr_data[31:0];
                R_CTL:          ctl_d       = csr_wr_data[31:0];
                R_CFG:          cfg_d       = csr_wr_data[31:0];
                R_INACT_THRESH: inact_d     = csr_wr_data[31:0];
                R_STRIDE:       stride_d    = csr_wr_data[31:0];
                default: ;
            endcase
        end

        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        if (rd_accept) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rd_data;
        end else if (csr_rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

`ifdef HE_LB_CSR_RD_ERR_EN
        rsp_err_d = rsp_err_q;
        if (rd_accept) begin
            rsp_err_d = rd_bad;
        end
        wr_err_d = wr_err_q | (csr_wr_valid && (wr_reg == R_NONE || wr_misalign));
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scratch_q   <= '0;
            dsm_base_q  <= '0;
            src_addr_q  <= '0;
            dst_addr_q  <= '0;
            num_lines_q <= '0;
            ctl_q       <= '0;
            cfg_q       <= '0;
            inact_q     <= '0;
            stride_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
`ifdef HE_LB_CSR_RD_ERR_EN
            rsp_err_q   <= 1'b0;
            wr_err_q    <= 1'b0;
`endif
        end else begin
            scratch_q   <= scratch_d;
            dsm_base_q  <= dsm_base_d;
            src_addr_q  <= src_addr_d;
            dst_addr_q  <= dst_addr_d;
            num_lines_q <= num_lines_d;
            ctl_q       <= ctl_d;
            cfg_q       <= cfg_d;
            inact_q     <= inact_d;
            stride_q    <= stride_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
`ifdef HE_LB_CSR_RD_ERR_EN
            rsp_err_q   <= rsp_err_d;
            wr_err_q    <= wr_err_d;
`endif
        end
    end

    he_lb_ctl_fsm u_ctl_fsm (
        .clk        (clk),
        .rst        (rst),
        .ctl_wr     (ctl_wr),
        .ctl_wdata  (csr_wr_data[2:0]),
        .eng_busy   (eng_busy),
        .eng_done   (eng_done),
        .eng_start  (eng_start),
        .eng_stop   (eng_stop),
        .fsm_state  (fsm_state),
        .run_cycles (run_cycles)
    );

    assign csr_rsp_valid    = rsp_valid_q;
    assign csr_rsp_data     = rsp_data_q;
`ifdef HE_LB_CSR_RD_ERR_EN
    assign csr_rsp_err      = rsp_err_q;
`endif
    assign cfg_src_addr     = src_addr_q;
    assign cfg_dst_addr     = dst_addr_q;
    assign cfg_num_lines    = num_lines_q;
    assign cfg_cfg          = cfg_q;
    assign cfg_stride       = stride_q;
    assign cfg_inact_thresh = inact_q;
    assign cfg_dsm_base     = dsm_base_q;
    assign eng_rst_n        = ctl_q[0];

endmodule

// File: tb/tb_he_lb_csr_block.sv
// Scoreboard bench for he_lb_csr_block. Build with or without HE_LB_CSR_RD_ERR_EN.
module tb_he_lb_csr_block;

    localparam logic [31:0] ENG_RD  = 32'h0000_1234;
    localparam logic [31:0] ENG_WR  = 32'h0000_5678;
    localparam logic [31:0] ENG_ERR = 32'h0000_0005;
    localparam logic [63:0] EXP_INFO0 = 64'd250 | (64'h02 << 16) | (64'd1 << 24) | (64'd1 << 25) | (64'd4 << 27);
    localparam logic [63:0] ALL     = '1;
    localparam logic [63:0] ST_MASK = 64'h0000_0007_0000_0000;

`ifdef HE_LB_CSR_RD_ERR_EN
    localparam bit ERR_EN = 1'b1;
    logic csr_rsp_err;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_wr_valid, csr_wr_ready, csr_wr_size;
    logic [15:0] csr_wr_addr;
    logic [63:0] csr_wr_data;
    logic        csr_rd_valid, csr_rd_ready, csr_rd_size;
    logic [15:0] csr_rd_addr;
    logic        csr_rsp_valid, csr_rsp_ready;
    logic [63:0] csr_rsp_data;
    logic [63:0] cfg_src_addr, cfg_dst_addr, cfg_dsm_base;
    logic [31:0] cfg_num_lines, cfg_cfg, cfg_stride, cfg_inact_thresh;
    logic        eng_rst_n, eng_start, eng_stop, eng_busy, eng_done;
    logic [31:0] eng_num_reads, eng_num_writes, eng_error;

    typedef struct {
        string       tag;
        logic [63:0] data;
        logic [63:0] mask;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t e_pop;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    he_lb_csr_block dut (
        .clk              (clk),
        .rst              (rst),
        .csr_wr_valid     (csr_wr_valid),
        .csr_wr_ready     (csr_wr_ready),
        .csr_wr_addr      (csr_wr_addr),
        .csr_wr_size      (csr_wr_size),
        .csr_wr_data      (csr_wr_data),
        .csr_rd_valid     (csr_rd_valid),
        .csr_rd_ready     (csr_rd_ready),
        .csr_rd_addr      (csr_rd_addr),
        .csr_rd_size      (csr_rd_size),
        .csr_rsp_valid    (csr_rsp_valid),
        .csr_rsp_ready    (csr_rsp_ready),
        .csr_rsp_data     (csr_rsp_data),
`ifdef HE_LB_CSR_RD_ERR_EN
        .csr_rsp_err      (csr_rsp_err),
`endif
        .cfg_src_addr     (cfg_src_addr),
        .cfg_dst_addr     (cfg_dst_addr),
        .cfg_num_lines    (cfg_num_lines),
        .cfg_cfg          (cfg_cfg),
        .cfg_stride       (cfg_stride),
        .cfg_inact_thresh (cfg_inact_thresh),
        .cfg_dsm_base     (cfg_dsm_base),
        .eng_rst_n        (eng_rst_n),
        .eng_start        (eng_start),
        .eng_stop         (eng_stop),
        .eng_busy         (eng_busy),
        .eng_done         (eng_done),
        .eng_num_reads    (eng_num_reads),
        .eng_num_writes   (eng_num_writes),
        .eng_error        (eng_error)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    endtask

    // Responses are compared mid-cycle when the handshake will complete at the next edge.
    always @(negedge clk) begin
        if (!rst && csr_rsp_valid && csr_rsp_ready) begin
            if (sb.size() == 0) begin
                check("sb_spurious", 64'd1, 64'd0);
            end else begin
                e_pop = sb.pop_front();
                check(e_pop.tag, csr_rsp_data & e_pop.mask, e_pop.data & e_pop.mask);
`ifdef HE_LB_CSR_RD_ERR_EN
                check({e_pop.tag, "_err"}, 64'(csr_rsp_err), 64'(e_pop.err));
`endif
            end
        end
    end

    task automatic csr_write(input logic [15:0] addr, input logic size, input logic [63:0] data);
        csr_wr_valid = 1'b1;
        csr_wr_addr  = addr;
        csr_wr_size  = size;
        csr_wr_data  = data;
        @(posedge clk); #1;
        csr_wr_valid = 1'b0;
    endtask

    task automatic csr_read(input string tag, input logic [15:0] addr, input logic size,
                            input logic [63:0] exp, input logic [63:0] mask, input logic err);
        exp_t e;
        int unsigned n = 0;
        while (!csr_rd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!csr_rd_ready) begin
            check({tag, "_rd_timeout"}, 64'(csr_rd_ready), 64'd1);
            return;
        end
        e.tag = tag; e.data = exp; e.mask = mask; e.err = err;
        sb.push_back(e);
        csr_rd_valid = 1'b1;
        csr_rd_addr  = addr;
        csr_rd_size  = size;
        @(posedge clk); #1;
        csr_rd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("sb_drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int unsigned starts;
        rst = 1'b1;
        csr_wr_valid = 1'b0; csr_wr_addr = '0; csr_wr_size = 1'b0; csr_wr_data = '0;
        csr_rd_valid = 1'b0; csr_rd_addr = '0; csr_rd_size = 1'b0;
        csr_rsp_ready = 1'b1;
        eng_busy = 1'b0; eng_done = 1'b0;
        eng_num_reads = ENG_RD; eng_num_writes = ENG_WR; eng_error = ENG_ERR;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", 64'(csr_rsp_valid), 64'd0);
        check("rst_src",       cfg_src_addr, 64'd0);
        check("rst_ctl_out",   {61'd0, eng_rst_n, eng_start, eng_stop}, 64'd0);
        check("rst_wr_ready",  64'(csr_wr_ready), 64'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        csr_read("rst_status1", 16'h0168, 1'b1, 64'd0, ALL, 1'b0);

        // Scratchpad: upper-word 32b write, then several views of the slot.
        csr_write(16'h0104, 1'b0, 64'h0000_0000_DEAD_BEEF);
        csr_read("scr1_32", 16'h0104, 1'b0, 64'h0000_0000_DEAD_BEEF, ALL, 1'b0);
        check("rsp_latency", 64'(csr_rsp_valid), 64'd1);
        csr_read("scr_64", 16'h0100, 1'b1, 64'hDEAD_BEEF_0000_0000, ALL, 1'b0);
        csr_read("scr0_32", 16'h0100, 1'b0, 64'd0, ALL, 1'b0);
        csr_read("info0", 16'h0180, 1'b1, EXP_INFO0, ALL, 1'b0);

        // Configuration registers.
        csr_write(16'h0120, 1'b1, 64'h1122_3344_5566_7788);
        check("cfg_src", cfg_src_addr, 64'h1122_3344_5566_7788);
        csr_write(16'h0128, 1'b0, 64'h0000_0000_AAAA_0001);
        csr_write(16'h012C, 1'b0, 64'h0000_0000_BBBB_0002);
        check("cfg_dst", cfg_dst_addr, 64'hBBBB_0002_AAAA_0001);
        csr_write(16'h0110, 1'b0, 64'h0000_0000_0000_1000);
        csr_write(16'h0114, 1'b0, 64'h0000_0000_0000_0002);
        check("cfg_dsm", cfg_dsm_base, 64'h0000_0002_0000_1000);
        csr_write(16'h0130, 1'b1, 64'hFFFF_FFFF_0000_0040);
        csr_write(16'h0134, 1'b0, 64'h0000_0000_0000_0005);
        check("cfg_lines", 64'(cfg_num_lines), 64'h40);
        csr_read("lines_64", 16'h0130, 1'b1, 64'h40, ALL, 1'b0);
        csr_write(16'h0140, 1'b0, 64'h0000_0000_0000_0F0F);
        csr_write(16'h0148, 1'b0, 64'h0000_0000_0000_0100);
        csr_write(16'h0178, 1'b0, 64'h0000_0000_0000_0003);
        check("cfg_misc", {cfg_cfg[15:0], cfg_inact_thresh[15:0], cfg_stride}, 64'h0F0F_0100_0000_0003);
        csr_write(16'h0160, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        csr_read("status0", 16'h0160, 1'b1, {ENG_WR, ENG_RD}, ALL, 1'b0);

        // Start: CTL=1 enables only, CTL=3 starts.
        csr_write(16'h0138, 1'b0, 64'd1);
        check("eng_rst_n", 64'(eng_rst_n), 64'd1);
        check("no_start_ctl1", 64'(eng_start), 64'd0);
        csr_write(16'h0138, 1'b0, 64'd3);
        starts = 32'(eng_start);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            starts += 32'(eng_start);
        end
        check("start_pulse", 64'(starts), 64'd1);
        csr_read("st_run", 16'h0168, 1'b1, 64'h1_0000_0000, ST_MASK, 1'b0);
        eng_done = 1'b1;
        @(posedge clk); #1;
        eng_done = 1'b0;
        csr_read("st_done", 16'h0168, 1'b1, 64'h3_0000_0000, ST_MASK, 1'b0);

        // Stop with engine busy; run_cycles counted exactly.
        csr_write(16'h0138, 1'b0, 64'd1);
        eng_busy = 1'b1;
        csr_write(16'h0138, 1'b0, 64'd3);
        csr_write(16'h0138, 1'b0, 64'd5);
        check("eng_stop_hi", 64'(eng_stop), 64'd1);
        csr_read("st_stopping", 16'h0168, 1'b1, 64'h2_0000_0000, ST_MASK, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        check("eng_stop_hold", 64'(eng_stop), 64'd1);
        eng_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("eng_stop_lo", 64'(eng_stop), 64'd0);
        csr_read("st_done_rc", 16'h0168, 1'b1, 64'h0000_0003_0000_000C, ALL, 1'b0);
        csr_write(16'h0138, 1'b0, 64'd0);
        check("eng_rst_n_lo", 64'(eng_rst_n), 64'd0);
        csr_read("st_idle", 16'h0168, 1'b1, 64'd0, ALL, 1'b0);
        wait_drain();

        // Backpressure: response held stable while not accepted.
        csr_rsp_ready = 1'b0;
        csr_read("bp_data", 16'h0100, 1'b1, 64'hDEAD_BEEF_0000_0000, ALL, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(csr_rsp_valid), 64'd1);
            check("bp_rd_ready", 64'(csr_rd_ready), 64'd0);
            check("bp_hold", csr_rsp_data, 64'hDEAD_BEEF_0000_0000);
            @(posedge clk); #1;
        end
        csr_rsp_ready = 1'b1;
        wait_drain();

        // Same-cycle write and read of SCRATCHPAD0 returns the old value.
        begin
            exp_t e;
            e.tag = "wr_rd_old"; e.data = 64'hDEAD_BEEF_0000_0000; e.mask = ALL; e.err = 1'b0;
            sb.push_back(e);
        end
        csr_wr_valid = 1'b1; csr_wr_addr = 16'h0100; csr_wr_size = 1'b1; csr_wr_data = 64'h1234_5678_9ABC_DEF0;
        csr_rd_valid = 1'b1; csr_rd_addr = 16'h0100; csr_rd_size = 1'b1;
        @(posedge clk); #1;
        csr_wr_valid = 1'b0; csr_rd_valid = 1'b0;
        csr_read("wr_rd_new", 16'h0100, 1'b1, 64'h1234_5678_9ABC_DEF0, ALL, 1'b0);

        // Unmapped / misaligned accesses.
        csr_read("unmapped", 16'h01F8, 1'b1, 64'd0, ALL, ERR_EN);
        csr_read("misalign_rd", 16'h0104, 1'b1, 64'd0, ALL, ERR_EN);
        csr_read("aligned32_hi", 16'h0104, 1'b0, 64'h0000_0000_1234_5678, ALL, 1'b0);
        csr_write(16'h0104, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        csr_read("misalign_wr", 16'h0100, 1'b1, 64'h1234_5678_9ABC_DEF0, ALL, 1'b0);
        csr_write(16'h01F8, 1'b1, 64'h1);
        csr_read("error", 16'h0170, 1'b0, {32'd0, ENG_ERR | (ERR_EN ? 32'h8000_0000 : 32'd0)}, ALL, 1'b0);
        wait_drain();

        // Reset with a response pending drops it.
        csr_write(16'h0138, 1'b0, 64'd1);
        csr_rsp_ready = 1'b0;
        csr_rd_valid = 1'b1; csr_rd_addr = 16'h0100; csr_rd_size = 1'b1;
        @(posedge clk); #1;
        csr_rd_valid = 1'b0;
        check("pend_valid", 64'(csr_rsp_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_drop_valid", 64'(csr_rsp_valid), 64'd0);
        check("rst_cfg64", cfg_src_addr | cfg_dst_addr | cfg_dsm_base, 64'd0);
        check("rst_cfg32", 64'(cfg_num_lines | cfg_cfg | cfg_stride | cfg_inact_thresh), 64'd0);
        check("rst_eng_rst_n", 64'(eng_rst_n), 64'd0);
        #2 rst = 1'b0;
        csr_rsp_ready = 1'b1;
        @(posedge clk); #1;
        csr_read("post_rst_scr", 16'h0100, 1'b1, 64'd0, ALL, 1'b0);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
